// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word, RAM port state and arbiter FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Status reported by the RAM model/controller for the current request.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter ownership of the single RAM port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of icache, dcache and RAM port signals around the memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: iwait/dwait stall the caches; ramstate paces the arbiter.
// Ports: slave = arbiter side, master = caches + RAM side (used by the bench).
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    // status
    logic      arb_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, arb_err
    );
endinterface

// File: rtl/cache_mem_arbiter_timer.sv
// Grant watchdog: counts grant cycles and flags the last allowed one.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clear has priority over enable.
// Ports: CLK, nRST (sync, active-low), clear_i, enable_i -> expired_o.
module arb_wait_timer #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count is 0 in the first grant cycle, so LAST marks grant cycle TIMEOUT;
    // the counter reaches TIMEOUT on the edge that ends it.
    assign expired_o = enable_i && (cnt_q == LAST);
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache requests onto one RAM port (IDLE/IGRANT/DGRANT).
// Latency: 1-cycle arbitration in IDLE, then the grant lasts until ramstate ACCESS.
// Backpressure: owner's wait drops only on ACCESS; non-owner wait = its request.
// Ports: CLK, nRST (sync, active-low), bus (cache_mem_arbiter_if.slave).
// Option: define ROUND_ROBIN_EN for last-served tie-breaking (default: dcache priority).
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic                  CLK,
    input  logic                  nRST,
    cache_mem_arbiter_if.slave    bus
);
    arb_state_t state_q, state_d;
    logic       arb_err_q, arb_err_d;
    logic       dreq;
    logic       d_wins;
    logic       expired;
    logic       timer_clear, timer_en;

`ifdef ROUND_ROBIN_EN
    // 0 = icache served last, 1 = dcache served last.
    logic last_q, last_d;
`endif

    assign dreq = bus.dREN | bus.dWEN;

`ifdef ROUND_ROBIN_EN
    // On a tie the side that was not served last wins.
    assign d_wins = dreq && (!bus.iREN || !last_q);
`else
    assign d_wins = dreq;
`endif

    assign timer_clear = (state_q == IDLE);
    assign timer_en    = (state_q != IDLE);

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .CLK       (CLK),
        .nRST      (nRST),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (expired)
    );

    // Read data is forwarded unconditionally; the wait lines qualify it.
    assign bus.iload   = bus.ramload;
    assign bus.dload   = bus.ramload;
    assign bus.arb_err = arb_err_q;

    always_comb begin
        state_d      = state_q;
        arb_err_d    = arb_err_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = bus.iREN;
        bus.dwait    = dreq;
`ifdef ROUND_ROBIN_EN
        last_d       = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d = DGRANT;
`ifdef ROUND_ROBIN_EN
                    last_d  = 1'b1;
`endif
                end else if (bus.iREN) begin
                    state_d = IGRANT;
`ifdef ROUND_ROBIN_EN
                    last_d  = 1'b0;
`endif
                end
            end

            DGRANT: begin
                // Owner wait stays high unless the access completes, so an
                // abandoned request never produces a false completion pulse.
                bus.dwait = 1'b1;
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait = 1'b0;
                        state_d   = IDLE;
                    end else if (bus.ramstate == ERROR || expired) begin
                        state_d   = IDLE;
                        arb_err_d = 1'b1;
                    end
                end
            end

            IGRANT: begin
                bus.iwait = 1'b1;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait = 1'b0;
                        state_d   = IDLE;
                    end else if (bus.ramstate == ERROR || expired) begin
                        state_d   = IDLE;
                        arb_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted the caches see plain IDLE behaviour; the RAM
        // port itself is released from the cycle after the reset edge.
        if (!nRST) begin
            bus.iwait = bus.iREN;
            bus.dwait = dreq;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            arb_err_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            arb_err_q <= arb_err_d;
`ifdef ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (TIMEOUT=64, TW=7).
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(
        .TIMEOUT (64),
        .TW      (7)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        nRST = 1'b0;

        // ---------------- reset ----------------
        next_cyc();
        bus.iREN = 1'b1;
        settle();
        checks++; if (bus.iwait !== 1'b1) fail("rst_iwait_idle_rule", bus.iwait, 1'b1);
        checks++; if (bus.dwait !== 1'b0) fail("rst_dwait_idle_rule", bus.dwait, 1'b0);
        checks++; if (bus.ramREN !== 1'b0) fail("rst_ramREN", bus.ramREN, 1'b0);
        next_cyc();
        bus.iREN = 1'b0;
        nRST = 1'b1;
        settle();
        checks++; if (bus.arb_err !== 1'b0) fail("rst_arb_err", bus.arb_err, 1'b0);
        checks++; if (bus.ramaddr !== 32'h0) fail("rst_ramaddr", bus.ramaddr, 32'h0);
        checks++; if (bus.iwait !== 1'b0) fail("rst_iwait", bus.iwait, 1'b0);

        // ---------------- both request: dcache first, icache after one IDLE ----------------
        bus.dREN = 1'b1; bus.iREN = 1'b1;
        bus.daddr = 32'h100; bus.iaddr = 32'h200;
        bus.ramstate = BUSY;
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("a_idle_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.dwait !== 1'b1) fail("a_idle_dwait", bus.dwait, 1'b1);
        next_cyc();
        settle();
        checks++; if (bus.ramREN !== 1'b1) fail("a_g1_ramREN", bus.ramREN, 1'b1);
        checks++; if (bus.ramaddr !== 32'h100) fail("a_g1_ramaddr", bus.ramaddr, 32'h100);
        checks++; if (bus.dwait !== 1'b1) fail("a_g1_dwait", bus.dwait, 1'b1);
        checks++; if (bus.iwait !== 1'b1) fail("a_g1_iwait", bus.iwait, 1'b1);
        next_cyc();
        bus.ramstate = ACCESS; bus.ramload = 32'h1234_5678;
        settle();
        checks++; if (bus.dwait !== 1'b0) fail("a_g2_dwait", bus.dwait, 1'b0);
        checks++; if (bus.dload !== 32'h1234_5678) fail("a_g2_dload", bus.dload, 32'h1234_5678);
        checks++; if (bus.iwait !== 1'b1) fail("a_g2_iwait", bus.iwait, 1'b1);
        next_cyc();
        bus.dREN = 1'b0; bus.ramstate = BUSY;
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("a_gap_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.iwait !== 1'b1) fail("a_gap_iwait", bus.iwait, 1'b1);
        next_cyc();
        settle();
        checks++; if (bus.ramREN !== 1'b1) fail("a_ig_ramREN", bus.ramREN, 1'b1);
        checks++; if (bus.ramaddr !== 32'h200) fail("a_ig_ramaddr", bus.ramaddr, 32'h200);
        checks++; if (bus.ramWEN !== 1'b0) fail("a_ig_ramWEN", bus.ramWEN, 1'b0);
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_F00D;
        settle();
        checks++; if (bus.iwait !== 1'b0) fail("a_ig_iwait", bus.iwait, 1'b0);
        checks++; if (bus.iload !== 32'hCAFE_F00D) fail("a_ig_iload", bus.iload, 32'hCAFE_F00D);
        next_cyc();
        clear_inputs();
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("a_end_ramREN", bus.ramREN, 1'b0);

        // ---------------- write beats read ----------------
        bus.dREN = 1'b1; bus.dWEN = 1'b1;
        bus.daddr = 32'h40; bus.dstore = 32'hDEAD_BEEF; bus.ramstate = BUSY;
        settle();
        checks++; if (bus.ramWEN !== 1'b0) fail("w_idle_ramWEN", bus.ramWEN, 1'b0);
        next_cyc();
        settle();
        checks++; if (bus.ramWEN !== 1'b1) fail("w_ramWEN", bus.ramWEN, 1'b1);
        checks++; if (bus.ramREN !== 1'b0) fail("w_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.ramaddr !== 32'h40) fail("w_ramaddr", bus.ramaddr, 32'h40);
        checks++; if (bus.ramstore !== 32'hDEAD_BEEF) fail("w_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        bus.ramstate = ACCESS;
        settle();
        checks++; if (bus.dwait !== 1'b0) fail("w_dwait", bus.dwait, 1'b0);
        next_cyc();
        clear_inputs();
        settle();

        // ---------------- owner drops request in first grant cycle ----------------
        bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = BUSY;
        next_cyc();
        bus.dREN = 1'b0;
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("drop_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.ramaddr !== 32'h0) fail("drop_ramaddr", bus.ramaddr, 32'h0);
        checks++; if (bus.dwait !== 1'b1) fail("drop_dwait", bus.dwait, 1'b1);
        next_cyc();
        bus.dREN = 1'b1;
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("drop_back_idle", bus.ramREN, 1'b0);
        next_cyc();
        bus.ramstate = ACCESS;
        settle();
        checks++; if (bus.ramREN !== 1'b1) fail("drop_regrant_ramREN", bus.ramREN, 1'b1);
        next_cyc();
        clear_inputs();
        settle();

        // ---------------- icache timeout with ramstate held BUSY ----------------
        bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.ramstate = BUSY;
        settle();
        for (int i = 0; i < 64; i++) begin
            next_cyc();
            settle();
            checks++; if (bus.ramREN !== 1'b1) fail("to_grant_ramREN", bus.ramREN, 1'b1);
            checks++; if (bus.iwait !== 1'b1) fail("to_grant_iwait", bus.iwait, 1'b1);
            checks++; if (bus.arb_err !== 1'b0) fail("to_grant_arb_err", bus.arb_err, 1'b0);
        end
        next_cyc();
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("to_abort_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.arb_err !== 1'b1) fail("to_arb_err", bus.arb_err, 1'b1);
        checks++; if (bus.iwait !== 1'b1) fail("to_iwait", bus.iwait, 1'b1);
        bus.iREN = 1'b0;
        next_cyc();
        settle();
        checks++; if (bus.arb_err !== 1'b1) fail("to_arb_err_sticky", bus.arb_err, 1'b1);

        // ---------------- reset for one cycle during DGRANT ----------------
        bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY;
        next_cyc();
        settle();
        checks++; if (bus.ramREN !== 1'b1) fail("r_grant_ramREN", bus.ramREN, 1'b1);
        nRST = 1'b0;
        settle();
        checks++; if (bus.dwait !== 1'b1) fail("r_in_rst_dwait", bus.dwait, 1'b1);
        next_cyc();
        nRST = 1'b1;
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("r_after_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.ramaddr !== 32'h0) fail("r_after_ramaddr", bus.ramaddr, 32'h0);
        checks++; if (bus.arb_err !== 1'b0) fail("r_after_arb_err", bus.arb_err, 1'b0);
        next_cyc();
        settle();
        checks++; if (bus.ramREN !== 1'b1) fail("r_rearb_ramREN", bus.ramREN, 1'b1);
        checks++; if (bus.ramaddr !== 32'h500) fail("r_rearb_ramaddr", bus.ramaddr, 32'h500);
        bus.ramstate = ERROR;
        settle();
        checks++; if (bus.dwait !== 1'b1) fail("err_dwait", bus.dwait, 1'b1);
        next_cyc();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        settle();
        checks++; if (bus.ramREN !== 1'b0) fail("err_ramREN", bus.ramREN, 1'b0);
        checks++; if (bus.arb_err !== 1'b1) fail("err_arb_err", bus.arb_err, 1'b1);

        // ---------------- continuous contention, ACCESS on every grant cycle ----------------
        nRST = 1'b0;
        next_cyc();
        nRST = 1'b1;
        bus.iREN = 1'b1; bus.dREN = 1'b1;
        bus.iaddr = 32'hA00; bus.daddr = 32'hD00; bus.ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            logic        exp_d;
            logic [31:0] exp_addr;
`ifdef ROUND_ROBIN_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            exp_addr = exp_d ? 32'hD00 : 32'hA00;
            settle();
            checks++; if (bus.ramREN !== 1'b0) fail("cont_idle_ramREN", bus.ramREN, 1'b0);
            next_cyc();
            settle();
            checks++; if (bus.ramaddr !== exp_addr) fail("cont_grant_ramaddr", bus.ramaddr, exp_addr);
            checks++; if (bus.dwait !== !exp_d) fail("cont_grant_dwait", bus.dwait, !exp_d);
            checks++; if (bus.iwait !== exp_d) fail("cont_grant_iwait", bus.iwait, exp_d);
            next_cyc();
        end
        clear_inputs();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
